// File: rtl/gpp_pkg.sv
// gpp_pkg -- shared definitions for the processor bus and its memory responder.
//   Bus geometry : WIDTH (data bits), AW (address bits), DEPTH (implemented words)
//   RW encodings : RD / WR
//   State types  : responder clear/ready states, processor sequencing states
package gpp_pkg;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Memory responder: zeroing walk after reset, then servicing requests.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } resp_state_e;

    // Processor-side sequencing states (used by the initiator).
    typedef enum logic [1:0] {
        P_FETCH     = 2'd0,
        P_DECODE    = 2'd1,
        P_EXECUTE   = 2'd2,
        P_WRITEBACK = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/gpp_mem_array.sv
// gpp_mem_array -- DEPTH x WIDTH word array, one shared address, one write
// port and one registered read port (suitable for block-RAM inference).
//   clk   : clock
//   srst  : synchronous active-high reset (clears the read register only)
//   we    : write enable, mem[addr] <= wdata on the edge
//   re    : read enable, rdata <= mem[addr] on the edge; rdata holds otherwise
//   addr  : word address (caller guarantees addr < DEPTH when we/re are set)
//   wdata : write data
//   rdata : registered read data
module gpp_mem_array
    import gpp_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int A  = AW,
    parameter int D  = DEPTH
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         we,
    input  logic         re,
    input  logic [A-1:0] addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [0:D-1];
    logic [W-1:0] rdata_q;

    // Storage itself has no reset; the responder zeroes it with a walk.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gpp_mem_responder.sv
// gpp_mem_responder -- word memory answering the processor bus.
// After reset every word is written to zero, one per cycle; Ready stays low
// until that walk completes. Then reads return data one cycle later with a
// Valid pulse, writes land silently, and bad requests raise an Err pulse.
//   Clk, Rst : clock, synchronous active-high reset
//   Addr     : word address          En    : request strobe
//   RW       : 0 read / 1 write      WData : write data
//   Data     : registered read data  Valid : read result present this cycle
//   Ready    : requests accepted     Err   : previous request rejected
module gpp_mem_responder
    import gpp_pkg::*;
#(
    parameter int WIDTH = gpp_pkg::WIDTH,
    parameter int AW    = gpp_pkg::AW,
    parameter int DEPTH = gpp_pkg::DEPTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [AW-1:0]    Addr,
    input  logic             En,
    input  logic             RW,
    input  logic [WIDTH-1:0] WData,
    output logic [WIDTH-1:0] Data,
    output logic             Valid,
    output logic             Ready,
    output logic             Err
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    resp_state_e      state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             in_range;
    logic             mem_we, mem_re;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    // Extra MSB keeps the compare correct when DEPTH == 2**AW.
    assign in_range = ({1'b0, Addr} < DEPTH_W);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = Addr;
        mem_wdata = WData;

        case (state_q)
            S_CLEAR: begin
                // The walk owns the array port; bus requests are refused.
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                err_d     = En;
                if (cnt_q == LAST) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READY: begin
                if (En) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (RW == WR) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_re  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        // Nothing touches the array on a reset edge.
        if (Rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    gpp_mem_array #(
        .W (WIDTH),
        .A (AW),
        .D (DEPTH)
    ) u_array (
        .clk   (Clk),
        .srst  (Rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (Data)
    );

    assign Valid = valid_q;
    assign Err   = err_q;
    assign Ready = (state_q == S_READY);

endmodule

// File: tb/tb_gpp_mem_responder.sv
module tb_gpp_mem_responder;

    logic        clk = 1'b0;
    logic        rst, en, rw;
    logic [3:0]  addr;
    logic [31:0] wdata, data;
    logic        valid, ready, err;

    logic        rst2, en2, rw2;
    logic [3:0]  addr2;
    logic [31:0] wdata2, data2;
    logic        valid2, ready2, err2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpp_mem_responder dut (
        .Clk(clk), .Rst(rst), .Addr(addr), .En(en), .RW(rw), .WData(wdata),
        .Data(data), .Valid(valid), .Ready(ready), .Err(err)
    );

    gpp_mem_responder #(.WIDTH(32), .AW(4), .DEPTH(12)) dut12 (
        .Clk(clk), .Rst(rst2), .Addr(addr2), .En(en2), .RW(rw2), .WData(wdata2),
        .Data(data2), .Valid(valid2), .Ready(ready2), .Err(err2)
    );

    // Reference model of the 16-word instance: contents, cycles since reset,
    // and what the outputs must show after the latest edge.
    logic [31:0] m_mem [16];
    int          m_clear = 0;
    logic [31:0] m_data  = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_ready = 1'b0;

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [3:0] a, input logic [31:0] d);
        logic rdy;
        rst = r; en = e; rw = w; addr = a; wdata = d;
        @(posedge clk);
        rdy = (m_clear >= 16);
        if (r) begin
            m_clear = 0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0; m_err = 1'b0;
            if (e) begin
                if (!rdy) m_err = 1'b1;
                else if (w) m_mem[a] = d;
                else begin m_data = m_mem[a]; m_valid = 1'b1; end
            end
            if (m_clear < 16) begin
                m_clear++;
                if (m_clear == 16) foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
        m_ready = (m_clear >= 16);
        #1;
    endtask

    task automatic step2(input logic e, input logic w, input logic [3:0] a,
                         input logic [31:0] d);
        en2 = e; rw2 = w; addr2 = a; wdata2 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        n_checks++;
        if ({data, valid, err, ready} !== {32'd0, 3'b000}) begin
            n_errors++;
            $display("FAIL reset_state: got d=%h v=%b e=%b r=%b, want d=0 v=0 e=0 r=0",
                     data, valid, err, ready);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            n_checks++;
            if (ready !== m_ready) begin
                n_errors++;
                $display("FAIL clear_ready cycle %0d: got %b want %b", i + 1, ready, m_ready);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 32'd0);
            n_checks++;
            if ({valid, err, data} !== {m_valid, m_err, m_data} || data !== 32'd0) begin
                n_errors++;
                $display("FAIL zero_read a=%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                         i, valid, err, data, m_valid, m_err, m_data);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read;
        step(1'b0, 1'b1, 1'b1, 4'd3, 32'h2008_0005);
        n_checks++;
        if ({valid, err} !== 2'b00) begin
            n_errors++;
            $display("FAIL write_quiet: got v=%b e=%b want 0 0", valid, err);
        end
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'd0);
        n_checks++;
        if ({valid, data} !== {1'b1, 32'h2008_0005}) begin
            n_errors++;
            $display("FAIL raw_read: got v=%b d=%h want v=1 d=20080005", valid, data);
        end
        step(1'b0, 1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF);
        n_checks++;
        if ({valid, err, data} !== {2'b00, 32'h2008_0005}) begin
            n_errors++;
            $display("FAIL data_hold: got v=%b e=%b d=%h want v=0 e=0 d=20080005",
                     valid, err, data);
        end
        $display("test_write_read done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'(i), vals[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 32'd0);
            n_checks++;
            if ({valid, err, data} !== {2'b10, vals[i]}) begin
                n_errors++;
                $display("FAIL b2b_read %0d: got v=%b e=%b d=%h want v=1 e=0 d=%h",
                         i, valid, err, data, vals[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_end: got v=%b want 0", valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_busy_request;
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            // Word 2 has already been cleared by cycle 5; a landed write would persist.
            if (i == 5) step(1'b0, 1'b1, 1'b1, 4'd2, 32'hDEAD_0002);
            else        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            n_checks++;
            if ({valid, err, ready} !== {m_valid, m_err, m_ready}) begin
                n_errors++;
                $display("FAIL busy cycle %0d: got v=%b e=%b r=%b want v=%b e=%b r=%b",
                         i, valid, err, ready, m_valid, m_err, m_ready);
            end
        end
        step(1'b0, 1'b1, 1'b0, 4'd2, 32'd0);
        n_checks++;
        if ({valid, data} !== {1'b1, 32'd0}) begin
            n_errors++;
            $display("FAIL busy_write_dropped: got v=%b d=%h want v=1 d=0", valid, data);
        end
        $display("test_busy_request done");
    endtask

    task automatic test_rst_mid_read;
        step(1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_ABCD);
        step(1'b1, 1'b1, 1'b0, 4'd7, 32'd0);
        n_checks++;
        if ({valid, err, ready} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_drop: got v=%b e=%b r=%b want 0 0 0", valid, err, ready);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            n_checks++;
            if (ready !== m_ready) begin
                n_errors++;
                $display("FAIL rerun_ready cycle %0d: got %b want %b", i, ready, m_ready);
            end
        end
        step(1'b0, 1'b1, 1'b0, 4'd7, 32'd0);
        n_checks++;
        if ({valid, data} !== {1'b1, 32'd0}) begin
            n_errors++;
            $display("FAIL rerun_cleared: got v=%b d=%h want v=1 d=0", valid, data);
        end
        $display("test_rst_mid_read done");
    endtask

    task automatic test_random;
        logic r, e, w;
        logic [3:0] a;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            step(r, e, w, a, d);
            n_checks++;
            if ({valid, err, ready, data} !== {m_valid, m_err, m_ready, m_data}) begin
                n_errors++;
                $display("FAIL random %0d: got v=%b e=%b r=%b d=%h want v=%b e=%b r=%b d=%h",
                         i, valid, err, ready, data, m_valid, m_err, m_ready, m_data);
            end
            if (valid && err) begin
                n_errors++;
                $display("FAIL random_exclusive %0d: valid and err both high", i);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_out_of_range;
        logic [31:0] e12 [12];
        rst2 = 1'b1; en2 = 1'b0;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            n_checks++;
            if (ready2 !== (i == 12)) begin
                n_errors++;
                $display("FAIL d12_ready cycle %0d: got %b want %b", i, ready2, (i == 12));
            end
            if (i < 12) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 12; i++) begin
            e12[i] = $urandom;
            step2(1'b1, 1'b1, 4'(i), e12[i]);
        end
        step2(1'b1, 1'b0, 4'd5, 32'd0);
        n_checks++;
        if ({valid2, err2, data2} !== {2'b10, e12[5]}) begin
            n_errors++;
            $display("FAIL d12_read5: got v=%b e=%b d=%h want v=1 e=0 d=%h",
                     valid2, err2, data2, e12[5]);
        end
        step2(1'b1, 1'b0, 4'd13, 32'd0);
        n_checks++;
        if ({valid2, err2, data2} !== {2'b01, e12[5]}) begin
            n_errors++;
            $display("FAIL d12_oor_read: got v=%b e=%b d=%h want v=0 e=1 d=%h",
                     valid2, err2, data2, e12[5]);
        end
        step2(1'b1, 1'b1, 4'd12, 32'hFFFF_FFFF);
        n_checks++;
        if ({valid2, err2} !== 2'b01) begin
            n_errors++;
            $display("FAIL d12_oor_write: got v=%b e=%b want v=0 e=1", valid2, err2);
        end
        step2(1'b0, 1'b0, 4'd0, 32'd0);
        n_checks++;
        if ({valid2, err2} !== 2'b00) begin
            n_errors++;
            $display("FAIL d12_err_pulse: got v=%b e=%b want 0 0", valid2, err2);
        end
        for (int i = 0; i < 12; i++) begin
            step2(1'b1, 1'b0, 4'(i), 32'd0);
            n_checks++;
            if ({valid2, data2} !== {1'b1, e12[i]}) begin
                n_errors++;
                $display("FAIL d12_intact a=%0d: got v=%b d=%h want v=1 d=%h",
                         i, valid2, data2, e12[i]);
            end
        end
        $display("test_out_of_range done");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        rst2 = 1'b1; en2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_busy_request();
        test_rst_mid_read();
        test_random();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
